// File: rtl/dispatch_pkg.sv
// Shared constants and types for the four-way dispatch demultiplexer.
// Channel count, select width and per-channel FIFO depth live here.
package dispatch_pkg;
    localparam int NUM_CH     = 4;
    localparam int SEL_W      = 2;
    localparam int FIFO_DEPTH = 2;

    typedef logic [1:0] cnt_t;
endpackage

// File: rtl/demux4_chan_fifo.sv
// Two-entry valid/ready FIFO for one dispatch channel.
// The head is driven from storage registers only; an empty FIFO drives zero.
module demux4_chan_fifo
    import dispatch_pkg::*;
#(
    parameter int data_size = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [data_size-1:0] din,
    input  logic                 pop,
    output logic [data_size-1:0] dout,
    output logic                 valid,
    output logic                 full
);
    logic [FIFO_DEPTH-1:0][data_size-1:0] mem_q, mem_d;
    logic                                 wr_ptr_q, wr_ptr_d;
    logic                                 rd_ptr_q, rd_ptr_d;
    cnt_t                                 cnt_q, cnt_d;
    logic                                 push_en, pop_en;

    assign valid = (cnt_q != 2'd0);
    assign full  = (cnt_q == cnt_t'(FIFO_DEPTH));
    assign dout  = valid ? mem_q[rd_ptr_q] : '0;

    // Guard both sides locally so count stays within 0..2 regardless of caller.
    always_comb begin
        push_en  = push & ~full;
        pop_en   = pop & valid;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_en) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_en, pop_en})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/demux4_dispatch.sv
// Four-way buffered demultiplexer: routes each accepted word to one of four
// independent channel FIFOs so a stalled consumer only blocks its own traffic.
module demux4_dispatch
    import dispatch_pkg::*;
#(
    parameter int data_size = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic [data_size-1:0] in_data,
    output logic [NUM_CH-1:0]    out_valid,
    input  logic [NUM_CH-1:0]    out_ready,
    output logic [data_size-1:0] out_data_0,
    output logic [data_size-1:0] out_data_1,
    output logic [data_size-1:0] out_data_2,
    output logic [data_size-1:0] out_data_3,
    output logic                 busy
);
    logic [NUM_CH-1:0]                ch_push;
    logic [NUM_CH-1:0]                ch_full;
    logic [NUM_CH-1:0][data_size-1:0] ch_dout;

    // in_ready looks only at registered fullness, never at out_ready.
    assign in_ready = ~ch_full[in_sel];
    assign busy     = |out_valid;

    always_comb begin
        ch_push = '0;
        if (in_valid && in_ready) begin
            ch_push[in_sel] = 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        demux4_chan_fifo #(.data_size(data_size)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (ch_push[k]),
            .din   (in_data),
            .pop   (out_ready[k]),
            .dout  (ch_dout[k]),
            .valid (out_valid[k]),
            .full  (ch_full[k])
        );
    end

    assign out_data_0 = ch_dout[0];
    assign out_data_1 = ch_dout[1];
    assign out_data_2 = ch_dout[2];
    assign out_data_3 = ch_dout[3];
endmodule

// File: doc/demux4_dispatch.md
# demux4_dispatch

Four-way buffered demultiplexer: accepts one valid/ready input stream tagged with a 2-bit destination select and delivers each word, in order, to one of four independent valid/ready output channels. It is the fan-out counterpart of the 4:1 data-select path and lets the datapath dispatch results, such as writeback data or crypto-unit operands, to one of four consumers without stalling the others. Each channel has its own 2-entry FIFO, so a stalled consumer blocks only traffic addressed to it.

## Interface
- `data_size`, 32, width of every data word
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous active-low reset
- `in_valid`  input  1  producer has a word
- `in_ready`  output  1  word addressed by `in_sel` can be accepted this cycle
- `in_sel`  input  2  destination channel 0..3
- `in_data`  input  data_size  word
- `out_valid`  output  4  bit k: channel k head is valid
- `out_ready`  input  4  bit k: consumer k takes head
- `out_data_0`..`out_data_3`  output  data_size  channel heads
- `busy`  output  1  any channel non-empty

## Operation
- Clock and reset are fixed: a single clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: all FIFOs empty, `out_valid` = 4'b0000, `busy` = 0, `out_data_k` = 0, all pointers and counts = 0.
- Per channel k: a 2-entry FIFO with a 1-bit write pointer, a 1-bit read pointer and a 2-bit count (range 0..2).
- `in_ready` = (count[in_sel] != 2). It depends only on `in_sel` and registered state, never on `out_ready`, and has no combinational path from any output-side input.
- Push: `in_valid & in_ready` writes `in_data` to channel `in_sel`. Only one channel is pushed per cycle.
- Pop: `out_valid[k] & out_ready[k]` advances channel k. Any number of channels may pop in the same cycle.
- Simultaneous push and pop on the same channel: the count is unchanged and both pointers advance. This is legal at count 1. At count 2 no push can occur because `in_ready` = 0, even if that channel pops the same cycle.
- `out_valid[k]` = (count[k] != 0). `out_data_k` = storage at the read pointer. It is driven only from registers; empty channels drive 0.
- Pointers wrap from 1 to 0. Count never exceeds 2 or goes below 0.
- When `in_valid` = 0, `in_sel` and `in_data` are don't-care and nothing changes on the input side.
- `ready` = 1 with `valid` = 0 is legal and has no effect.
- `busy` = OR of `out_valid`.
- Ordering: words to the same channel leave in arrival order. There is no ordering guarantee across channels.
- Reset asserted mid-operation: all state clears immediately and buffered words are discarded.

## Timing
- Latency: a word accepted at edge N appears with `out_valid` = 1 after edge N. Minimum latency is 1 cycle; there is no combinational bypass.
- Throughput: 1 word per cycle into any channel whose consumer holds `out_ready` = 1 continuously.
- Producer rule: once `in_valid` = 1, `in_data` and `in_sel` are held stable until accepted.
- Block guarantee: `out_valid` / `out_data_k` stay stable until popped.
- Back-pressure: after two unpopped pushes to channel k, `in_ready` drops for `in_sel` = k. It rises in the cycle after the first pop.

## Structure
- A shared package `dispatch_pkg` holds:
  - `NUM_CH` = 4
  - `SEL_W` = 2
  - `FIFO_DEPTH` = 2
  - count type `logic [1:0]`
- Sub-module `demux4_chan_fifo` (parameter `data_size`; ports `clk`, `rst_n`, `push`, `din`, `pop`, `dout`, `valid`, `full`) is instantiated four times.
- The top level contains only push decode, `in_ready` select and `busy` reduction.

## Test plan
- Reset: hold `rst_n` = 0 and drive random inputs → `out_valid` = 0000, `in_ready` = 1 for every `in_sel`, `busy` = 0. Release; the first push of 32'hA5A5_0001 to channel 2 gives `out_valid` = 0100 one edge later.
- Fill/back-pressure: with `out_ready` = 0000, push 32'h11 and 32'h22 to channel 1 → `in_ready` = 0 for `in_sel` = 1 and 1 for `in_sel` = 0. Raise `out_ready[1]` → 32'h11 then 32'h22 pop in order, and `in_ready` returns 1 the cycle after the first pop.
- Streaming: `out_ready` = 1111; push 0..99 cycling `in_sel` 0,1,2,3 every cycle → no stall; each channel sees its 25 words in order, each 1 cycle after acceptance.
- Isolation: block channel 3 (2 words buffered), then push 32'hBEEF to channel 0 → accepted and delivered while channel 3 stays full and unchanged.
- Same-cycle push/pop at count 1 on channel 2 → count stays 1, the new word follows the old one, and no word is lost or duplicated.
- Mid-operation reset: with channels 0 and 3 holding data, pulse `rst_n` low asynchronously between edges → `out_valid` = 0000 immediately; after release the old data never appears.
